// File: rtl/mips_instr_encoder_if.sv
// Request and instruction-memory write bundle for mips_instr_encoder.
// master drives requests and wr_ready; slave is the encoder.
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 6
) ();
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_kind;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [4:0]        req_shamt;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   words_written;
  logic              err;

  modport master (
    output req_valid, req_kind, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target, wr_ready,
    input  req_ready, wr_valid, wr_addr, wr_data, words_written, err
  );

  modport slave (
    input  req_valid, req_kind, req_rs, req_rt, req_rd, req_shamt, req_imm, req_target, wr_ready,
    output req_ready, wr_valid, wr_addr, wr_data, words_written, err
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// Encodes instruction requests into MIPS words, buffers them and streams them to instruction memory.
// Optional macro ENC_FIELD_CHECK_EN: requests with nonzero unused fields are dropped and flag err.
module mips_instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  mips_instr_encoder_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef ENC_FIELD_CHECK_EN
  localparam bit FIELD_CHECK = 1'b1;
`else
  localparam bit FIELD_CHECK = 1'b0;
`endif

  localparam logic [4:0] K_ADD  = 5'd0;
  localparam logic [4:0] K_SUB  = 5'd1;
  localparam logic [4:0] K_AND  = 5'd2;
  localparam logic [4:0] K_OR   = 5'd3;
  localparam logic [4:0] K_SLT  = 5'd4;
  localparam logic [4:0] K_XOR  = 5'd5;
  localparam logic [4:0] K_SRL  = 5'd6;
  localparam logic [4:0] K_SRLV = 5'd7;
  localparam logic [4:0] K_JR   = 5'd8;
  localparam logic [4:0] K_LW   = 5'd9;
  localparam logic [4:0] K_SW   = 5'd10;
  localparam logic [4:0] K_BEQ  = 5'd11;
  localparam logic [4:0] K_BLTZ = 5'd12;
  localparam logic [4:0] K_BGTZ = 5'd13;
  localparam logic [4:0] K_ADDI = 5'd14;
  localparam logic [4:0] K_J    = 5'd15;
  localparam logic [4:0] K_ANDI = 5'd16;
  localparam logic [4:0] K_ORI  = 5'd17;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] funct);
    return {6'h00, rs, rt, rd, sh, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  logic [31:0]       mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   written_r;
  logic              err_r;

  logic [31:0] enc_word_s;
  logic        enc_legal_s;
  logic        unused_nz_s;
  logic        reject_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;

  logic rs_nz_s, rt_nz_s, rd_nz_s, sh_nz_s, imm_nz_s, tgt_nz_s;
  logic r3_unused_s, i_unused_s;

  assign rs_nz_s     = |bus.req_rs;
  assign rt_nz_s     = |bus.req_rt;
  assign rd_nz_s     = |bus.req_rd;
  assign sh_nz_s     = |bus.req_shamt;
  assign imm_nz_s    = |bus.req_imm;
  assign tgt_nz_s    = |bus.req_target;
  assign r3_unused_s = sh_nz_s | imm_nz_s | tgt_nz_s;
  assign i_unused_s  = rd_nz_s | sh_nz_s | tgt_nz_s;

  // Encode the current request and flag illegal kinds and nonzero unused fields
  always_comb begin
    enc_word_s  = 32'h0000_0000;
    enc_legal_s = 1'b1;
    unused_nz_s = 1'b0;
    case (bus.req_kind)
      K_ADD:  begin enc_word_s = r_word(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h20); unused_nz_s = r3_unused_s; end
      K_SUB:  begin enc_word_s = r_word(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h22); unused_nz_s = r3_unused_s; end
      K_AND:  begin enc_word_s = r_word(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h24); unused_nz_s = r3_unused_s; end
      K_OR:   begin enc_word_s = r_word(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h25); unused_nz_s = r3_unused_s; end
      K_SLT:  begin enc_word_s = r_word(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h2A); unused_nz_s = r3_unused_s; end
      K_XOR:  begin enc_word_s = r_word(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h26); unused_nz_s = r3_unused_s; end
      K_SRLV: begin enc_word_s = r_word(bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h06); unused_nz_s = r3_unused_s; end
      K_SRL: begin
        enc_word_s  = r_word(5'd0, bus.req_rt, bus.req_rd, bus.req_shamt, 6'h02);
        unused_nz_s = rs_nz_s | imm_nz_s | tgt_nz_s;
      end
      K_JR: begin
        enc_word_s  = r_word(bus.req_rs, 5'd0, 5'd0, 5'd0, 6'h08);
        unused_nz_s = rt_nz_s | rd_nz_s | sh_nz_s | imm_nz_s | tgt_nz_s;
      end
      K_LW:   begin enc_word_s = i_word(6'h23, bus.req_rs, bus.req_rt, bus.req_imm); unused_nz_s = i_unused_s; end
      K_SW:   begin enc_word_s = i_word(6'h2B, bus.req_rs, bus.req_rt, bus.req_imm); unused_nz_s = i_unused_s; end
      K_BEQ:  begin enc_word_s = i_word(6'h04, bus.req_rs, bus.req_rt, bus.req_imm); unused_nz_s = i_unused_s; end
      K_ADDI: begin enc_word_s = i_word(6'h08, bus.req_rs, bus.req_rt, bus.req_imm); unused_nz_s = i_unused_s; end
      K_ANDI: begin enc_word_s = i_word(6'h0C, bus.req_rs, bus.req_rt, bus.req_imm); unused_nz_s = i_unused_s; end
      K_ORI:  begin enc_word_s = i_word(6'h0D, bus.req_rs, bus.req_rt, bus.req_imm); unused_nz_s = i_unused_s; end
      K_BLTZ: begin enc_word_s = i_word(6'h01, bus.req_rs, 5'd0, bus.req_imm); unused_nz_s = rt_nz_s | i_unused_s; end
      K_BGTZ: begin enc_word_s = i_word(6'h07, bus.req_rs, 5'd0, bus.req_imm); unused_nz_s = rt_nz_s | i_unused_s; end
      K_J: begin
        enc_word_s  = {6'h02, bus.req_target};
        unused_nz_s = rs_nz_s | rt_nz_s | rd_nz_s | sh_nz_s | imm_nz_s;
      end
      default: enc_legal_s = 1'b0;
    endcase
  end

  // A full FIFO never accepts, even when the head pops this cycle
  assign bus.req_ready = (count_r < CNT_W'(DEPTH)) & ~clr;
  assign reject_s      = ~enc_legal_s | (FIELD_CHECK & unused_nz_s);
  assign accept_s      = bus.req_valid & bus.req_ready;
  assign push_s        = accept_s & ~reject_s;
  assign pop_s         = bus.wr_valid & bus.wr_ready;

  assign bus.wr_valid      = (count_r != {CNT_W{1'b0}});
  assign bus.wr_data       = bus.wr_valid ? mem_r[rd_ptr_r] : 32'h0000_0000;
  assign bus.wr_addr       = addr_r;
  assign bus.words_written = written_r;
  assign bus.err           = err_r;

  // FIFO storage; stale entries are never visible because wr_data is gated by wr_valid
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= enc_word_s;
    end
  end

  // Pointers, occupancy, address counter, write count and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      written_r <= {(ADDR_W+1){1'b0}};
      err_r     <= 1'b0;
    end else if (clr) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      addr_r    <= {ADDR_W{1'b0}};
      written_r <= {(ADDR_W+1){1'b0}};
      err_r     <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
        addr_r   <= addr_r + ADDR_W'(1'b1);
        if (written_r != {(ADDR_W+1){1'b1}}) begin
          written_r <= written_r + (ADDR_W+1)'(1'b1);
        end
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
      if (accept_s & reject_s) begin
        err_r <= 1'b1;
      end
    end
  end
endmodule
